// File: rtl/gate_arbiter_if.sv
// Gate arbiter lane bus: coin/push requests in, lane status and counters out.
// The master drives requests; the slave (the arbiter) returns status.
interface gate_arbiter_if #(
    parameter int CREDIT_W = 8
);
    logic [1:0]          coin_i;
    logic [1:0]          push_i;
    logic [1:0]          locked_o;
    logic [1:0]          unlocked_o;
    logic [1:0]          deny_o;
    logic [CREDIT_W-1:0] credit_o;
    logic [15:0]         pass_count_o;

    modport master (
        output coin_i,
        output push_i,
        input  locked_o,
        input  unlocked_o,
        input  deny_o,
        input  credit_o,
        input  pass_count_o
    );

    modport slave (
        input  coin_i,
        input  push_i,
        output locked_o,
        output unlocked_o,
        output deny_o,
        output credit_o,
        output pass_count_o
    );
endinterface

// File: rtl/gate_arbiter.sv
// Two-lane turnstile arbiter sharing one credit pool, round-robin on contention.
// Optional grant counter enabled by macro GATE_ARBITER_PASS_COUNT_EN.
module gate_arbiter #(
    parameter int CREDIT_W    = 8,
    parameter int PASS_CYCLES = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    gate_arbiter_if.slave bus
);
    localparam logic [0:0] LOCKED = 1'b0;
    localparam logic [0:0] PASS   = 1'b1;

    localparam logic [3:0] PASS_LAST = 4'(PASS_CYCLES - 1);

    localparam int SUM_W = CREDIT_W + 2;
    localparam logic [SUM_W-1:0] CREDIT_MAX = {2'b00, {CREDIT_W{1'b1}}};

    logic [0:0]          state_q [2];
    logic [3:0]          left_q  [2];
    logic                ptr_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [1:0]          deny_q;

    logic [1:0]          elig;
    logic [1:0]          grant;
    logic [1:0]          deny_d;
    logic [1:0]          n_grant;
    logic [1:0]          n_coin;
    logic [SUM_W-1:0]    credit_sum;
    logic [CREDIT_W-1:0] credit_d;
    logic                credit_zero;
    logic                credit_one;

    // A lane can request only while it sits locked.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            elig[n] = bus.push_i[n] && (state_q[n] == LOCKED);
        end
    end

    assign credit_zero = (credit_q == '0);
    assign credit_one  = (credit_q == CREDIT_W'(1));

    // Grant/deny decision from the registered credit pool.
    always_comb begin
        grant  = 2'b00;
        deny_d = 2'b00;
        unique case (1'b1)
            credit_zero: begin
                deny_d = elig;
            end
            (elig == 2'b11) && credit_one: begin
                grant[ptr_q]  = 1'b1;
                deny_d[~ptr_q] = 1'b1;
            end
            default: begin
                grant = elig;
            end
        endcase
    end

    assign n_grant = {1'b0, grant[0]} + {1'b0, grant[1]};
    assign n_coin  = {1'b0, bus.coin_i[0]} + {1'b0, bus.coin_i[1]};

    // Grants never exceed the pool, so the difference cannot go negative.
    always_comb begin
        credit_sum = SUM_W'(credit_q) + SUM_W'(n_coin) - SUM_W'(n_grant);
        if (credit_sum > CREDIT_MAX) begin
            credit_d = CREDIT_MAX[CREDIT_W-1:0];
        end else begin
            credit_d = credit_sum[CREDIT_W-1:0];
        end
    end

    // Per-lane LOCKED/PASS state machines with a pass-length countdown.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int n = 0; n < 2; n++) begin
                state_q[n] <= LOCKED;
                left_q[n]  <= 4'd0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                unique case (state_q[n])
                    LOCKED: begin
                        if (grant[n]) begin
                            state_q[n] <= PASS;
                            left_q[n]  <= PASS_LAST;
                        end
                    end
                    PASS: begin
                        if (left_q[n] == 4'd0) begin
                            state_q[n] <= LOCKED;
                        end else begin
                            left_q[n] <= left_q[n] - 4'd1;
                        end
                    end
                    default: begin
                        state_q[n] <= LOCKED;
                        left_q[n]  <= 4'd0;
                    end
                endcase
            end
        end
    end

    // Credit pool, deny pulses and the round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            credit_q <= '0;
            deny_q   <= 2'b00;
            ptr_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            deny_q   <= deny_d;
            if (grant == 2'b01 || grant == 2'b10) begin
                ptr_q <= ~ptr_q;
            end
        end
    end

`ifdef GATE_ARBITER_PASS_COUNT_EN
    logic [15:0] count_q;

    // Running total of grants, wrapping at 16 bits.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_q + 16'(n_grant);
        end
    end

    assign bus.pass_count_o = count_q;
`else
    assign bus.pass_count_o = 16'd0;
`endif

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            bus.unlocked_o[n] = (state_q[n] == PASS);
        end
    end

    assign bus.locked_o = ~bus.unlocked_o;
    assign bus.deny_o   = deny_q;
    assign bus.credit_o = credit_q;
endmodule

// File: tb/tb_gate_arbiter.sv
// Randomized bench for gate_arbiter against a lane/credit reference model.
// Directed scenarios pin the model with literal expectations.
module tb_gate_arbiter;
    localparam int CREDIT_W    = 8;
    localparam int PASS_CYCLES = 2;
    localparam int CMAX        = (1 << CREDIT_W) - 1;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    int m_credit;
    int m_left [2];
    int m_ptr;
    int m_deny [2];
    int m_count;

    gate_arbiter_if #(.CREDIT_W(CREDIT_W)) bus ();

    gate_arbiter #(
        .CREDIT_W   (CREDIT_W),
        .PASS_CYCLES(PASS_CYCLES)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_credit = 0;
        m_ptr    = 0;
        m_count  = 0;
        for (int n = 0; n < 2; n++) begin
            m_left[n] = 0;
            m_deny[n] = 0;
        end
    endtask

    task automatic model_step(input logic r, input logic [1:0] c, input logic [1:0] p);
        int e [2];
        int g [2];
        int ne;
        int ng;
        int nc;
        if (!r) begin
            model_reset();
            return;
        end
        ne = 0;
        for (int n = 0; n < 2; n++) begin
            e[n] = (p[n] && m_left[n] == 0) ? 1 : 0;
            g[n] = 0;
            m_deny[n] = 0;
            ne += e[n];
        end
        if (ne > 0) begin
            if (m_credit >= ne) begin
                g[0] = e[0];
                g[1] = e[1];
            end else if (m_credit == 0) begin
                m_deny[0] = e[0];
                m_deny[1] = e[1];
            end else begin
                g[m_ptr]     = 1;
                m_deny[1 - m_ptr] = 1;
            end
        end
        ng = g[0] + g[1];
        nc = int'(c[0]) + int'(c[1]);
        if (ng == 1) m_ptr = 1 - m_ptr;
        m_credit = m_credit + nc - ng;
        if (m_credit > CMAX) m_credit = CMAX;
        for (int n = 0; n < 2; n++) begin
            if (g[n] != 0) m_left[n] = PASS_CYCLES;
            else if (m_left[n] > 0) m_left[n] = m_left[n] - 1;
        end
`ifdef GATE_ARBITER_PASS_COUNT_EN
        m_count = (m_count + ng) % 65536;
`endif
    endtask

    task automatic compare_all();
        int eu;
        eu = (m_left[0] > 0 ? 1 : 0) + (m_left[1] > 0 ? 2 : 0);
        check("unlocked", int'(bus.unlocked_o), eu);
        check("locked", int'(bus.locked_o), 3 - eu);
        check("deny", int'(bus.deny_o), m_deny[0] + 2 * m_deny[1]);
        check("credit", int'(bus.credit_o), m_credit);
        check("pass_count", int'(bus.pass_count_o), m_count);
    endtask

    task automatic step(input logic r, input logic [1:0] c, input logic [1:0] p);
        @(negedge clk);
        rst_n = r;
        bus.coin_i = c;
        bus.push_i = p;
        @(posedge clk);
        model_step(r, c, p);
        #1;
        compare_all();
    endtask

    initial begin
        logic [1:0] c;
        logic [1:0] p;
        logic r;
        rst_n = 1'b0;
        bus.coin_i = 2'b11;
        bus.push_i = 2'b11;
        model_reset();

        step(1'b0, 2'b11, 2'b11);
        step(1'b0, 2'b11, 2'b11);
        check("rst_credit", int'(bus.credit_o), 0);
        check("rst_locked", int'(bus.locked_o), 3);
        check("rst_unlocked", int'(bus.unlocked_o), 0);

        for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 2'b00);
        check("coin5_credit", int'(bus.credit_o), 5);
        step(1'b1, 2'b00, 2'b01);
        check("grant0_unlocked", int'(bus.unlocked_o), 1);
        check("grant0_credit", int'(bus.credit_o), 4);
        step(1'b1, 2'b00, 2'b00);
        check("pass0_cycle2", int'(bus.unlocked_o), 1);
        step(1'b1, 2'b00, 2'b00);
        check("pass0_over", int'(bus.unlocked_o), 0);

        step(1'b0, 2'b00, 2'b00);
        step(1'b1, 2'b01, 2'b00);
        step(1'b1, 2'b00, 2'b11);
        check("rr0_unlocked", int'(bus.unlocked_o), 1);
        check("rr0_deny", int'(bus.deny_o), 2);
        step(1'b1, 2'b01, 2'b00);
        step(1'b1, 2'b00, 2'b00);
        step(1'b1, 2'b00, 2'b11);
        check("rr1_unlocked", int'(bus.unlocked_o), 2);
        check("rr1_deny", int'(bus.deny_o), 1);
        check("rr1_credit", int'(bus.credit_o), 0);

        step(1'b1, 2'b01, 2'b01);
        check("coin_same_deny", int'(bus.deny_o), 1);
        check("coin_same_credit", int'(bus.credit_o), 1);

        for (int i = 0; i < 130; i++) step(1'b1, 2'b11, 2'b00);
        check("sat_credit", int'(bus.credit_o), 255);
        step(1'b1, 2'b11, 2'b01);
        check("sat_net_credit", int'(bus.credit_o), 255);
        check("sat_grant", int'(bus.unlocked_o), 1);

        step(1'b1, 2'b00, 2'b01);
        check("held_credit", int'(bus.credit_o), 255);
        check("held_deny", int'(bus.deny_o), 0);
        step(1'b1, 2'b00, 2'b01);
        check("held_locked", int'(bus.unlocked_o), 0);
        step(1'b1, 2'b00, 2'b01);
        check("held_regrant", int'(bus.unlocked_o), 1);
        check("held_regrant_credit", int'(bus.credit_o), 254);

        step(1'b0, 2'b00, 2'b00);
        for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 2'b00);
        step(1'b1, 2'b00, 2'b01);
        check("pre_rst_credit", int'(bus.credit_o), 3);
        step(1'b0, 2'b11, 2'b11);
        check("mid_rst_unlocked", int'(bus.unlocked_o), 0);
        check("mid_rst_credit", int'(bus.credit_o), 0);
        check("mid_rst_count", int'(bus.pass_count_o), 0);

        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            c[0] = ($urandom_range(0, 3) == 0);
            c[1] = ($urandom_range(0, 3) == 0);
            p = 2'($urandom_range(0, 3));
            step(r, c, p);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gate_arbiter.md
GATE_ARBITER -- requirements
Module: gate_arbiter

Interface
REQ-001 The block SHALL have parameter CREDIT_W, default 8, credit counter width.
REQ-002 The block SHALL have parameter PASS_CYCLES, default 2, cycles a lane stays unlocked per grant (range 1..15).
REQ-003 The block SHALL have port clk_i, input, 1, single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1, reset; synchronous, active-low.
REQ-005 The block SHALL have port coin_i, input, 2, per-lane coin strobe; each high bit adds one credit that cycle.
REQ-006 The block SHALL have port push_i, input, 2, per-lane passage request.
REQ-007 The block SHALL have port locked_o, output, 2, lane n locked (bit-wise complement of unlocked_o).
REQ-008 The block SHALL have port unlocked_o, output, 2, lane n open for passage.
REQ-009 The block SHALL have port deny_o, output, 2, one-cycle pulse: lane n request refused.
REQ-010 The block SHALL have port credit_o, output, CREDIT_W, shared credit pool.
REQ-011 The block SHALL have port pass_count_o, output, 16, total grants issued (see Configuration).

Function
REQ-012 Each lane SHALL run a two-state FSM: LOCKED, PASS.
REQ-013 LOCKED -> PASS SHALL occur when the lane is granted; PASS SHALL last exactly PASS_CYCLES cycles, then return to LOCKED.
REQ-014 unlocked_o[n] SHALL be 1 exactly while lane n is in PASS; all outputs SHALL be registered.
REQ-015 A lane SHALL be eligible when push_i[n]=1 and it is in LOCKED; push_i in PASS SHALL be ignored (no credit consumed, no deny).
REQ-016 Arbitration SHALL use the registered credit_o value of the sampling cycle; a coin in cycle N SHALL NOT fund a push in cycle N.
REQ-017 Credit >= number of eligible lanes: every eligible lane SHALL be granted.
REQ-018 Credit = 1 with both lanes eligible: the lane selected by the round-robin pointer SHALL be granted, the other SHALL receive deny_o.
REQ-019 Credit = 0: every eligible lane SHALL receive deny_o.
REQ-020 Round-robin pointer SHALL move to the other lane after any cycle in which exactly one lane is granted; otherwise it SHALL hold.
REQ-021 Grant latency: push sampled in cycle N SHALL produce unlocked_o=1 (or deny_o=1) in cycle N+1.
REQ-022 Credit update SHALL be next = current + popcount(coin_i) - grants, computed in one step; simultaneous coin and grant SHALL net.
REQ-023 Credit SHALL saturate at 2^CREDIT_W-1; excess coins SHALL be discarded; credit SHALL never underflow.
REQ-024 deny_o SHALL be a single-cycle pulse per sampled refused request; a held push_i in LOCKED SHALL re-request every cycle.

Reset
REQ-025 With rst_ni=0 at a rising edge, next cycle: both lanes LOCKED, locked_o=2'b11, unlocked_o=2'b00, deny_o=2'b00, credit_o=0, pass_count_o=0, pointer=lane 0.
REQ-026 Reset mid-PASS SHALL abort the pass immediately; credit SHALL be lost, not refunded.
REQ-027 Inputs SHALL be ignored while rst_ni=0.

Configuration
REQ-028 Macro GATE_ARBITER_PASS_COUNT_EN defined: pass_count_o SHALL increment by number of grants per cycle (0..2), wrapping modulo 2^16.
REQ-029 Macro not defined: pass_count_o SHALL be constant 0 and no counter logic SHALL be synthesized; all other behaviour identical.

Verification
REQ-030 Reset release, coin_i=2'b01 for 5 cycles -> credit_o=5; then push_i=2'b01 one cycle -> unlocked_o[0]=1 for 2 cycles, credit_o=4.
REQ-031 credit_o=1, push_i=2'b11 one cycle from reset pointer -> lane 0 granted, deny_o=2'b10; repeat with credit 1 -> lane 1 granted, deny_o=2'b01.
REQ-032 credit_o=0, push_i=2'b01 with coin_i=2'b01 same cycle -> deny_o=2'b01, credit_o=1 next cycle.
REQ-033 credit_o=255, coin_i=2'b11 with push_i=2'b01 -> credit_o=255 (saturated net +1), lane 0 granted.
REQ-034 Lane 0 in PASS, push_i[0] held high -> credit unchanged during PASS; one new grant on first LOCKED cycle if credit > 0.
REQ-035 rst_ni=0 during PASS with credit 3 -> next cycle unlocked_o=0, credit_o=0; with GATE_ARBITER_PASS_COUNT_EN pass_count_o=0, without it always 0.
